// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle between the ALU-control decoder and the serial ALU.
// The master issues operands and an op code; the slave answers with busy/done and the result.
interface serial_alu_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alu_control;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;

   modport master (
      output start, a, b, alu_control,
      input  busy, done, result, zero, overflow
   );

   modport slave (
      input  start, a, b, alu_control,
      output busy, done, result, zero, overflow
   );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU: one bit_alu slice is reused LSB->MSB, one bit per clock.
// The carry is recirculated through a flop, and SLT is resolved in a final FIX cycle.
module bit_alu (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       a_invert_i,
   input  logic       b_invert_i,
   input  logic       carry_in_i,
   input  logic       less_i,
   input  logic [1:0] operation_i,
   output logic       result_o,
   output logic       carry_out_o
);
   logic aa, bb;

   assign aa          = a_i ^ a_invert_i;
   assign bb          = b_i ^ b_invert_i;
   assign carry_out_o = (aa & bb) | (aa & carry_in_i) | (bb & carry_in_i);

   always_comb begin
      case (operation_i)
         2'b00:   result_o = aa & bb;
         2'b01:   result_o = aa | bb;
         2'b10:   result_o = aa ^ bb ^ carry_in_i;
         default: result_o = less_i;
      endcase
   end
endmodule

module serial_alu_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   serial_alu_ctrl_if.slave     bus
);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   function automatic logic b_inv_of(input logic [3:0] c);
      return (c == OP_SUB) || (c == OP_SLT) || (c == OP_NOR);
   endfunction

   function automatic logic is_arith(input logic [3:0] c);
      return (c == OP_ADD) || (c == OP_SUB) || (c == OP_SLT);
   endfunction

   function automatic logic is_valid(input logic [3:0] c);
      return is_arith(c) || (c == OP_AND) || (c == OP_OR) || (c == OP_NOR);
   endfunction

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, res_q, res_d;
   logic [3:0]       ctl_q, ctl_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d, ovf_q, ovf_d, set_q, set_d;
   logic             zero_q, zero_d, ovfo_q, ovfo_d;
   logic             ovf_now;

   logic       a_inv, b_inv, s_res, s_co;
   logic [1:0] s_op;

   // Decode is taken from the latched code so input changes after acceptance are harmless.
   assign a_inv = (ctl_q == OP_NOR);
   assign b_inv = b_inv_of(ctl_q);
   assign s_op  = is_arith(ctl_q) ? 2'b10 : (ctl_q == OP_OR) ? 2'b01 : 2'b00;

   bit_alu u_slice (
      .a_i         (a_q[idx_q]),
      .b_i         (b_q[idx_q]),
      .a_invert_i  (a_inv),
      .b_invert_i  (b_inv),
      .carry_in_i  (carry_q),
      .less_i      (1'b0),
      .operation_i (s_op),
      .result_o    (s_res),
      .carry_out_o (s_co)
   );

   assign ovf_now = carry_q ^ s_co;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ctl_d   = ctl_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      sr_d    = sr_q;
      ovf_d   = ovf_q;
      set_d   = set_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ovfo_d  = ovfo_q;
      case (state_q)
         S_IDLE: if (bus.start) begin
            a_d     = bus.a;
            b_d     = bus.b;
            ctl_d   = bus.alu_control;
            idx_d   = '0;
            carry_d = b_inv_of(bus.alu_control);
            state_d = S_RUN;
         end
         S_RUN: begin
            sr_d    = {s_res, sr_q[WIDTH-1:1]};
            carry_d = s_co;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
               ovf_d = ovf_now;
               set_d = s_res ^ ovf_now;
               if (ctl_q == OP_SLT) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_DONE;
                  res_d   = is_valid(ctl_q) ? sr_d : '0;
                  zero_d  = (res_d == '0);
                  ovfo_d  = is_arith(ctl_q) & ovf_now;
               end
            end
         end
         S_FIX: begin
            sr_d    = {{(WIDTH-1){1'b0}}, set_q};
            res_d   = sr_d;
            zero_d  = ~set_q;
            ovfo_d  = ovf_q;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ctl_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sr_q    <= '0;
         ovf_q   <= 1'b0;
         set_q   <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ovfo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctl_q   <= ctl_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sr_q    <= sr_d;
         ovf_q   <= ovf_d;
         set_q   <= set_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ovfo_q  <= ovfo_d;
      end
   end

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.result   = res_q;
   assign bus.zero     = zero_q;
   assign bus.overflow = ovfo_q;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Random and directed stimulus for serial_alu_ctrl, checked against a word-level
// arithmetic model of each operation.
module tb_serial_alu_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] last_res = '0;

   serial_alu_ctrl_if #(.WIDTH(32)) bus ();

   serial_alu_ctrl #(.WIDTH(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // Word-level reference: result, zero flag, overflow flag, latency in edges incl. acceptance.
   task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic z, output logic v, output int lat);
      logic [31:0] d;
      d   = x - y;
      r   = '0;
      v   = 1'b0;
      lat = 33;
      case (op)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b0010: begin
            r = x + y;
            v = (x[31] == y[31]) && (r[31] != x[31]);
         end
         4'b0110: begin
            r = d;
            v = (x[31] != y[31]) && (d[31] != x[31]);
         end
         4'b0111: begin
            r   = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            v   = (x[31] != y[31]) && (d[31] != x[31]);
            lat = 34;
         end
         4'b1100: r = ~(x | y);
         default: r = '0;
      endcase
      z = (r == 0);
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input bit poke_start);
      logic [31:0] er;
      logic ez, ev;
      int   elat, edges, busyc;
      model(op, x, y, er, ez, ev, elat);
      @(negedge clk);
      bus.start = 1'b1; bus.a = x; bus.b = y; bus.alu_control = op;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.alu_control = 4'($urandom);
      edges = 1;
      busyc = bus.busy ? 1 : 0;
      while (!bus.done && edges < 60) begin
         @(posedge clk); #1;
         edges++;
         if (bus.busy) busyc++;
         if (edges == 10) chk({tag, ".hold"}, bus.result, last_res);
         bus.start = poke_start && (edges == 5 || edges == 20);
      end
      bus.start = 1'b0;
      chk({tag, ".lat"}, edges, elat);
      chk({tag, ".busy"}, busyc, elat);
      chk({tag, ".res"}, bus.result, er);
      chk({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, ez});
      chk({tag, ".ovf"}, {31'b0, bus.overflow}, {31'b0, ev});
      @(posedge clk); #1;
      chk({tag, ".end"}, {30'b0, bus.busy, bus.done}, 32'd0);
      chk({tag, ".kept"}, bus.result, er);
      last_res = er;
   endtask

   initial begin
      logic [3:0] ops [8];
      logic seen_done;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_control = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.out", {27'b0, bus.busy, bus.done, bus.zero, bus.overflow, |bus.result}, 32'd0);
      rst = 1'b0;

      run_op("add7_5",   4'b0010, 32'd7, 32'd5, 1'b1);
      run_op("sub_eq",   4'b0110, 32'h1234_5678, 32'h1234_5678, 1'b0);
      run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0);
      run_op("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op("slt_ovf",  4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
      run_op("slt_ge",   4'b0111, 32'd5, 32'd3, 1'b0);
      run_op("nor",      4'b1100, 32'd0, 32'h0000_00FF, 1'b0);
      run_op("and",      4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
      run_op("or",       4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
      run_op("badop",    4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

      for (int i = 0; i < 16; i++) begin
         logic [31:0] x, y;
         x = $urandom;
         y = (i % 4 == 0) ? x : $urandom;
         run_op("rnd", ops[$urandom_range(0, 7)], x, y, ($urandom_range(0, 1) == 1));
      end

      // Reset mid-SUB: outputs clear and the abandoned operation never completes.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd3; bus.alu_control = 4'b0110;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst.out", {27'b0, bus.busy, bus.done, bus.zero, bus.overflow, |bus.result}, 32'd0);
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) seen_done = 1'b1;
      end
      chk("midrst.quiet", {31'b0, seen_done}, 32'd0);
      last_res = '0;
      run_op("add1_1", 4'b0010, 32'd1, 32'd1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
